echo_sequencer: RTL
===================

Name: echo_sequencer

Overview:
Triggered RF pulse-sequence controller for the spin-echo/Ramsey experiments. On a trigger edge it plays dead time, pi/2, then n_pi repetitions of (tau, pi, tau), then a closing pi/2 and an acquisition window.
- Drives the rf line to the RF controller and an acq gate to the readout.
- Durations are runtime inputs in clk cycles and are latched at sequence start.
- Sits between the MCU-configured register bank and the RF switch pin.

Parameters:
CNT_W, 32, width of duration inputs; internal segment counter is CNT_W+1 bits so that the pi length 2*pi2_cyc cannot overflow
NPI_W, 8, width of the n_pi repetition count
SYNC_STAGES, 2, flip-flop stages on the asynchronous trig input

Ports:
clk  in  1  fpga clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
trig  in  1  external trigger, asynchronous to clk; a rising edge starts a sequence
arm  in  1  level enable; sequence starts only while high; deassertion aborts a running sequence
dead_cyc  in  CNT_W  dead-time length
pi2_cyc  in  CNT_W  pi/2 pulse length; pi pulse is 2*pi2_cyc
tau_cyc  in  CNT_W  half inter-pulse interval
n_pi  in  NPI_W  number of pi pulses; 0 = Ramsey
acq_cyc  in  CNT_W  acquisition window length
rf  out  1  RF enable, registered
acq  out  1  acquisition gate, registered
busy  out  1  high from the first DEAD cycle through the last ACQ cycle
seg  out  3  current state code, for debug/LED
done  out  1  one-cycle pulse after a completed sequence
aborted  out  1  one-cycle pulse on abort
cfg_err  out  1  one-cycle pulse when a start is refused
missed_trig  out  1  one-cycle pulse for a trigger edge seen while busy

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0, latched config 0. Reset is asynchronous and takes effect mid-sequence with no done or aborted pulse.
- Trigger sync: trig passes SYNC_STAGES flops, then an edge detector. The edge pulse (trg_e) appears SYNC_STAGES+1 cycles after the pin rises.
- States: IDLE=0, DEAD=1, P2A=2, TAU1=3, PI=4, TAU2=5, P2B=6, ACQ=7. seg equals the state code.
- Start condition: IDLE and trg_e and arm.
  - If pi2_cyc==0, stay IDLE and pulse cfg_err.
  - Otherwise latch all config inputs, set remaining = n_pi, and enter DEAD on the next cycle.
- Segment length: each segment lasts exactly its latched length L in cycles. A segment with L==0 is skipped: zero cycles, no output glitch. PI length is 2*pi2 in CNT_W+1 bits. The counter reloads at every segment entry.
- Transitions:
  - DEAD -> P2A -> TAU1.
  - TAU1 -> PI when remaining>0; TAU1 -> P2B when remaining==0.
  - PI -> TAU2, with remaining decremented on PI exit.
  - TAU2 -> TAU1 when remaining>0, giving a 2*tau gap; TAU2 -> P2B when remaining==0.
  - P2B -> ACQ -> IDLE.
- Outputs by state:
  - rf=1 exactly in P2A, PI and P2B.
  - acq=1 exactly in ACQ.
  - Both are registered and change on the same edge as seg.
- done: pulses on the first IDLE cycle after completion.
- Total busy cycles:
  - n_pi=0: dead + 2*pi2 + tau + acq.
  - n_pi>0: dead + 2*pi2 + n_pi*(2*tau + 2*pi2) + acq.
- Config inputs changing while busy have no effect until the next start.
- Trigger while busy: ignored; pulse missed_trig.
- Trigger in the same cycle as ACQ->IDLE: ignored, missed_trig pulsed.
- Abort: arm low in any non-IDLE state. Next cycle is IDLE with rf=acq=0, plus an aborted pulse and no done.
- Re-arm: an edge while arm is low is ignored silently.

Decomposition:
- ctrl_pkg holds the state encoding constants (IDLE..ACQ) and the default CNT_W/NPI_W.
- One sub-module, trig_sync: SYNC_STAGES synchroniser plus rising-edge detector, with ports clk, rst, async_in, edge_out.
- The FSM, segment counter and repetition counter stay in echo_sequencer.

Test Plan:
1. arm=1, dead=5, pi2=3, tau=4, n_pi=1, acq=6; trig rises.
   - busy high 31 cycles.
   - rf high runs: 3 cycles, then 6 cycles after a 4-cycle gap, then 3 cycles after a 4-cycle gap.
   - acq high 6 cycles, then one done pulse.
2. Ramsey, n_pi=0, dead=0, pi2=2, tau=10, acq=0.
   - DEAD skipped; rf 2 high, 10 low, 2 high.
   - busy 14 cycles, done pulsed, acq never high.
3. n_pi=3, tau=2, pi2=1.
   - Exactly 3 PI segments of 2 cycles.
   - Inter-pi gaps of 4 cycles; first and last gaps are 2 cycles.
4. Second trig edge mid-sequence.
   - missed_trig pulses once; timing of the running sequence is unchanged.
5. arm drops during PI.
   - Next cycle: rf=0, seg=0, aborted=1, no done.
   - A later trig with arm=1 runs a full sequence.
6. Boundary and reset cases:
   - pi2_cyc=0 start: cfg_err pulses, busy stays 0.
   - rst asserted mid-TAU1: rf/acq/busy go 0 asynchronously, with no done or aborted pulse.

Source files
------------

// File: rtl/echo_sequencer_pkg.sv
// Shared state encoding and default widths for the spin-echo pulse sequencer.
package ctrl_pkg;

   localparam int CNT_W_DEF = 32;
   localparam int NPI_W_DEF = 8;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      DEAD = 3'd1,
      P2A  = 3'd2,
      TAU1 = 3'd3,
      PI   = 3'd4,
      TAU2 = 3'd5,
      P2B  = 3'd6,
      ACQ  = 3'd7
   } state_t;

   function automatic logic is_rf(state_t s);
      return (s == P2A) || (s == PI) || (s == P2B);
   endfunction

endpackage

// File: rtl/echo_sequencer_trig_sync.sv
// Synchroniser for the asynchronous trigger pin followed by a registered rising-edge detector.
module trig_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic edge_out
);

   // sh[STAGES-1] is the synchronised level, sh[STAGES] its previous value
   logic [STAGES:0] sh;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh       <= '0;
         edge_out <= 1'b0;
      end else begin
         sh       <= {sh[STAGES-1:0], async_in};
         edge_out <= sh[STAGES-1] & ~sh[STAGES];
      end
   end

endmodule

// File: rtl/echo_sequencer.sv
// Triggered spin-echo / Ramsey sequencer: dead, pi/2, n x (tau, pi, tau), pi/2, acquisition.
module echo_sequencer
   import ctrl_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int NPI_W       = NPI_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             trig,
   input  logic             arm,
   input  logic [CNT_W-1:0] dead_cyc,
   input  logic [CNT_W-1:0] pi2_cyc,
   input  logic [CNT_W-1:0] tau_cyc,
   input  logic [NPI_W-1:0] n_pi,
   input  logic [CNT_W-1:0] acq_cyc,
   output logic             rf,
   output logic             acq,
   output logic             busy,
   output logic [2:0]       seg,
   output logic             done,
   output logic             aborted,
   output logic             cfg_err,
   output logic             missed_trig
);

   state_t           state, nxt;
   logic [CNT_W:0]   cnt, nxt_len;
   logic [CNT_W-1:0] dead_l, pi2_l, tau_l, acq_l;
   logic [NPI_W-1:0] rem, rem_n;
   logic             trg_e;

   trig_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (trig),
      .edge_out (trg_e)
   );

   function automatic logic [CNT_W:0] seg_len(state_t s, logic [CNT_W-1:0] d, logic [CNT_W-1:0] p,
                                               logic [CNT_W-1:0] t, logic [CNT_W-1:0] a);
      case (s)
         DEAD:       return {1'b0, d};
         P2A, P2B:   return {1'b0, p};
         TAU1, TAU2: return {1'b0, t};
         PI:         return {p, 1'b0};
         ACQ:        return {1'b0, a};
         default:    return '0;
      endcase
   endfunction

   // Zero-length tau/acq segments are folded into the successor so they take no cycles
   always_comb begin
      rem_n = rem;
      nxt   = IDLE;
      case (state)
         DEAD: nxt = P2A;
         P2A:  nxt = (tau_l != '0) ? TAU1 : ((rem != '0) ? PI : P2B);
         TAU1: nxt = (rem != '0) ? PI : P2B;
         PI: begin
            rem_n = rem - 1'b1;
            nxt   = (tau_l != '0) ? TAU2 : ((rem_n != '0) ? PI : P2B);
         end
         TAU2: nxt = (rem != '0) ? TAU1 : P2B;
         P2B:  nxt = (acq_l != '0) ? ACQ : IDLE;
         default: nxt = IDLE;
      endcase
      nxt_len = seg_len(nxt, dead_l, pi2_l, tau_l, acq_l);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         rem         <= '0;
         dead_l      <= '0;
         pi2_l       <= '0;
         tau_l       <= '0;
         acq_l       <= '0;
         rf          <= 1'b0;
         acq         <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         aborted     <= 1'b0;
         cfg_err     <= 1'b0;
         missed_trig <= 1'b0;
      end else begin
         done        <= 1'b0;
         aborted     <= 1'b0;
         cfg_err     <= 1'b0;
         missed_trig <= 1'b0;
         if (state == IDLE) begin
            if (trg_e && arm) begin
               if (pi2_cyc == '0) begin
                  cfg_err <= 1'b1;
               end else begin
                  dead_l <= dead_cyc;
                  pi2_l  <= pi2_cyc;
                  tau_l  <= tau_cyc;
                  acq_l  <= acq_cyc;
                  rem    <= n_pi;
                  busy   <= 1'b1;
                  if (dead_cyc != '0) begin
                     state <= DEAD;
                     cnt   <= {1'b0, dead_cyc};
                  end else begin
                     state <= P2A;
                     cnt   <= {1'b0, pi2_cyc};
                     rf    <= 1'b1;
                  end
               end
            end
         end else if (!arm) begin
            state       <= IDLE;
            cnt         <= '0;
            rf          <= 1'b0;
            acq         <= 1'b0;
            busy        <= 1'b0;
            aborted     <= 1'b1;
            missed_trig <= trg_e;
         end else begin
            missed_trig <= trg_e;
            // cnt counts down to 1 inside a segment; the last cycle loads the next segment
            if (cnt[CNT_W:1] == '0) begin
               state <= nxt;
               cnt   <= nxt_len;
               rem   <= rem_n;
               rf    <= is_rf(nxt);
               acq   <= (nxt == ACQ);
               busy  <= (nxt != IDLE);
               done  <= (nxt == IDLE);
            end else begin
               cnt <= cnt - 1'b1;
            end
         end
      end
   end

   assign seg = state;

endmodule
